mult_div_unit: RTL and testbench

- Iterative multiply/divide unit for the MIPS core; executes MULT, MULTU, DIV and DIVU.
- Produces the HI/LO write-back that the register file's HI/LO write port consumes: hi_lo_register_write_enable, HI_write_data and LO_write_data.
- Sits beside the ALU in the execute stage; the pipeline stalls on busy.

---
 rtl/mult_div_unit.sv | 126 ++++++++++++
 tb/tb_mult_div_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring shift-subtract step per cycle,
// then sign fix-up and a one-cycle HI/LO write strobe. Define MULT_DIV_FLUSH_EN to honour flush.
module mult_div_unit #(
  parameter int WIDTH      = 32,
  parameter int ITERATIONS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy,
  output logic             hi_lo_register_write_enable,
  output logic [WIDTH-1:0] HI_write_data,
  output logic [WIDTH-1:0] LO_write_data
);
  localparam int CW = $clog2(ITERATIONS + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIXUP, WRITE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic             is_div, neg_q, neg_r, b_zero;
  logic [WIDTH:0]   hi_acc;
  logic [WIDTH-1:0] lo_acc, b_mag;
  logic             kill, take;

  // operand magnitudes; op[0]=0 selects the signed variants
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  assign a_neg = ~op[0] & operand_a[WIDTH-1];
  assign b_neg = ~op[0] & operand_b[WIDTH-1];
  assign a_abs = a_neg ? -operand_a : operand_a;
  assign b_abs = b_neg ? -operand_b : operand_b;

  // multiply step: conditional add into the high half, then shift the pair right
  logic [WIDTH:0] sum;
  assign sum = {1'b0, hi_acc[WIDTH-1:0]} + {1'b0, (lo_acc[0] ? b_mag : {WIDTH{1'b0}})};

  // divide step: shift the next dividend bit into the remainder and try a subtract
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  assign shifted = {hi_acc[WIDTH-1:0], lo_acc[WIDTH-1]};
  assign diff    = {1'b0, shifted} - {2'b00, b_mag};

  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   q_s, r_s;
  assign prod   = {hi_acc[WIDTH-1:0], lo_acc};
  assign prod_s = neg_q ? -prod : prod;
  assign q_s    = b_zero ? {WIDTH{1'b1}} : (neg_q ? -lo_acc : lo_acc);
  assign r_s    = neg_r ? -hi_acc[WIDTH-1:0] : hi_acc[WIDTH-1:0];

`ifndef MULT_DIV_FLUSH_EN
  logic unused_flush;
  assign unused_flush = flush;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    kill      = 1'b0;
`ifdef MULT_DIV_FLUSH_EN
    kill      = flush;
`endif
    case (state)
      IDLE:  if (start && !kill) begin
               take      = 1'b1;
               state_nxt = RUN;
             end
      RUN:   if (kill) state_nxt = IDLE;
             else if (count == CW'(ITERATIONS - 1)) state_nxt = FIXUP;
      FIXUP: state_nxt = kill ? IDLE : WRITE;
      // the instruction has committed by WRITE, so flush no longer cancels it
      WRITE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count         <= '0;
      is_div        <= 1'b0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      b_zero        <= 1'b0;
      hi_acc        <= '0;
      lo_acc        <= '0;
      b_mag         <= '0;
      HI_write_data <= '0;
      LO_write_data <= '0;
    end else begin
      if (take) begin
        count  <= '0;
        is_div <= op[1];
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        b_zero <= op[1] && (operand_b == '0);
        hi_acc <= '0;
        lo_acc <= op[1] ? a_abs : b_abs;
        b_mag  <= op[1] ? b_abs : a_abs;
      end else if (state == RUN) begin
        count <= count + 1'b1;
        if (is_div) begin
          hi_acc <= diff[WIDTH+1] ? shifted : diff[WIDTH:0];
          lo_acc <= {lo_acc[WIDTH-2:0], ~diff[WIDTH+1]};
        end else begin
          hi_acc <= {1'b0, sum[WIDTH:1]};
          lo_acc <= {sum[0], lo_acc[WIDTH-1:1]};
        end
      end else if (state == FIXUP && !kill) begin
        HI_write_data <= is_div ? r_s : prod_s[2*WIDTH-1:WIDTH];
        LO_write_data <= is_div ? q_s : prod_s[WIDTH-1:0];
      end
    end
  end

  assign busy                        = (state != IDLE);
  assign hi_lo_register_write_enable = (state == WRITE);
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected {HI,LO} queued at start, checked on each strobe.
`timescale 1ns/1ps
module tb_mult_div_unit;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, we;
  logic [31:0] hi, lo;

  int n_vec = 0, n_err = 0, n_strobe = 0;
  logic [63:0] sb[$];
  logic [63:0] last = '0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(a), .operand_b(b), .flush(flush),
    .busy(busy), .hi_lo_register_write_enable(we),
    .HI_write_data(hi), .LO_write_data(lo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && we) begin
      logic [63:0] e;
      n_strobe++;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got hi=%h lo=%h, expected no write", hi, lo);
      end else begin
        e = sb.pop_front();
        if ({hi, lo} !== e) begin
          n_err++;
          $display("FAIL result: got hi=%h lo=%h, expected hi=%h lo=%h", hi, lo, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drive a start at a negedge; the following posedge is E0.
  task automatic drive(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp);
    drive(o, x, y);
    sb.push_back(exp);
    last = exp;
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
      end
      if (k == 0 || k >= 32) begin
        n_vec++;
        if (we !== (k == 33) || busy !== (k <= 33)) begin
          n_err++;
          $display("FAIL %s_timing@E%0d: got we=%b busy=%b, expected we=%b busy=%b",
                   name, k, we, busy, (k == 33), (k <= 33));
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #12;
    n_vec++;
    if ({busy, we, hi, lo} !== 66'd0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b we=%b hi=%h lo=%h, expected all 0", busy, we, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult;
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'h0000_0007, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
  endtask

  task automatic test_div;
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
    run_op("divu_zero", 2'b11, 32'h0000_0064, 32'h0000_0000, {32'h0000_0064, 32'hFFFF_FFFF});
    run_op("div_zero",  2'b10, 32'hFFFF_FFFB, 32'h0000_0000, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
  endtask

  task automatic test_back_to_back;
    run_op("b2b_mult", 2'b00, 32'h7FFF_FFFF, 32'h8000_0000, {32'hC000_0000, 32'h8000_0000});
    run_op("b2b_divu", 2'b11, 32'hFFFF_FFFF, 32'h0000_0010, {32'h0000_000F, 32'h0FFF_FFFF});
  endtask

  task automatic test_busy;
    int s0;
    s0 = n_strobe;
    drive(2'b11, 32'd100, 32'd7);
    sb.push_back({32'd2, 32'd14});
    last = {32'd2, 32'd14};
    for (int k = 0; k <= 36; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == 9) begin start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3; end
      if (k == 10) start = 1'b0;
    end
    n_vec++;
    if (n_strobe - s0 != 1 || sb.size() != 0) begin
      n_err++;
      $display("FAIL busy_ignore: got %0d strobes (%0d pending), expected 1 (0 pending)",
               n_strobe - s0, sb.size());
    end
  endtask

  task automatic test_flush;
    int s0;
    s0 = n_strobe;
    drive(2'b01, 32'd5, 32'd5);
`ifndef MULT_DIV_FLUSH_EN
    sb.push_back({32'd0, 32'd25});
`endif
    for (int k = 0; k <= 36; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == 19) flush = 1'b1;
      if (k == 20) begin
        flush = 1'b0;
`ifdef MULT_DIV_FLUSH_EN
        n_vec++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL flush_busy: got busy=%b, expected 0", busy);
        end
`endif
      end
    end
    n_vec++;
`ifdef MULT_DIV_FLUSH_EN
    if (n_strobe != s0 || {hi, lo} !== last) begin
      n_err++;
      $display("FAIL flush_cancel: got %0d strobes hi=%h lo=%h, expected 0 strobes hi=%h lo=%h",
               n_strobe - s0, hi, lo, last[63:32], last[31:0]);
    end
    // flush alongside start in IDLE must not launch an operation
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_start: got busy=%b, expected 0", busy);
    end
`else
    last = {32'd0, 32'd25};
    if (n_strobe - s0 != 1) begin
      n_err++;
      $display("FAIL flush_ignored: got %0d strobes, expected 1", n_strobe - s0);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int s0;
    s0 = n_strobe;
    drive(2'b01, 32'd5, 32'd5);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({busy, we, hi, lo} !== 66'd0) begin
      n_err++;
      $display("FAIL reset_mid: got busy=%b we=%b hi=%h lo=%h, expected all 0", busy, we, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    n_vec++;
    if (n_strobe != s0 || {hi, lo} !== 64'd0) begin
      n_err++;
      $display("FAIL reset_nowrite: got %0d strobes hi=%h lo=%h, expected 0 strobes hi=0 lo=0",
               n_strobe - s0, hi, lo);
    end
    run_op("after_reset", 2'b01, 32'd5, 32'd5, {32'd0, 32'd25});
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_back_to_back;
    test_busy;
    test_flush;
    test_reset_mid;
    repeat (3) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending results, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
